address_decoder_programmable: RTL

Runtime-programmable, multi-range address decoder with a pipelined valid/ready lookup path. It holds RANGE_COUNT base/bound windows, each written through a configuration port. Each accepted address is compared against every enabled window. The block reports the per-range match vector, an any-hit flag and the lowest-numbered matching range index. It sits between a bus master and the peripheral select logic, where decode windows must change at run time without re-synthesis.

---
 rtl/address_decoder_programmable.sv | 138 +++++++++++++
 1 files changed

// File: rtl/address_decoder_programmable.sv
// Programmable multi-range address decoder.
// It holds RANGE_COUNT base/bound/enable windows, which are written through a
// strobe-only configuration port. Lookups pass through two registered
// stages. S1 holds the accepted address. S2 holds the decode result, which is
// taken from the range table as it stands on the edge that S2 loads.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// when valid and ready are both high. A producer holds valid and its payload
// stable until the transfer. The ready signal may depend combinationally on
// the downstream ready (addr_ready follows hit_ready), but it never depends on
// the valid of its own port.
module address_decoder_programmable #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RANGE_COUNT = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cfg_valid,
  input  logic [INDEX_WIDTH-1:0] cfg_index,
  input  logic [ADDR_WIDTH-1:0]  cfg_base,
  input  logic [ADDR_WIDTH-1:0]  cfg_bound,
  input  logic                   cfg_enable,
  input  logic                   addr_valid,
  output logic                   addr_ready,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic                   hit_valid,
  input  logic                   hit_ready,
  output logic                   hit,
  output logic [RANGE_COUNT-1:0] hit_vector,
  output logic [INDEX_WIDTH-1:0] hit_index
);

  // Range table
  logic [ADDR_WIDTH-1:0]  base_q  [RANGE_COUNT];
  logic [ADDR_WIDTH-1:0]  bound_q [RANGE_COUNT];
  logic [RANGE_COUNT-1:0] enable_q;

  // Pipeline state
  logic                   s1_valid;
  logic [ADDR_WIDTH-1:0]  s1_addr;
  logic                   s2_valid;
  logic                   s2_hit;
  logic [RANGE_COUNT-1:0] s2_vector;
  logic [INDEX_WIDTH-1:0] s2_index;

  // Flow control and decode results
  logic                   s2_free;
  logic                   s2_load;
  logic                   addr_fire;
  logic [RANGE_COUNT-1:0] match_vector;
  logic [INDEX_WIDTH-1:0] match_index;

  // S2 can take new data when it is empty, or when its result leaves this cycle.
  assign s2_free   = !s2_valid || hit_ready;
  assign s2_load   = s1_valid && s2_free;
  assign addr_ready = !s1_valid || s2_free;
  assign addr_fire = addr_valid && addr_ready;

  assign hit_valid  = s2_valid;
  assign hit        = s2_hit;
  assign hit_vector = s2_vector;
  assign hit_index  = s2_index;

  // Configuration write: replace base, bound and enable of the addressed range.
  // An index with no matching range falls through every compare and is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < RANGE_COUNT; r++) begin
        base_q[r]  <= '0;
        bound_q[r] <= '0;
      end
      enable_q <= '0;
    end else if (cfg_valid) begin
      for (int r = 0; r < RANGE_COUNT; r++) begin
        if (cfg_index == INDEX_WIDTH'(r)) begin
          base_q[r]   <= cfg_base;
          bound_q[r]  <= cfg_bound;
          enable_q[r] <= cfg_enable;
        end
      end
    end
  end

  // Full-width unsigned window compare of the S1 address against every range.
  // If base > bound, the two compares cannot both hold, so the window never matches.
  always_comb begin
    match_vector = '0;
    for (int r = 0; r < RANGE_COUNT; r++) begin
      match_vector[r] = enable_q[r] && (s1_addr >= base_q[r]) && (s1_addr <= bound_q[r]);
    end
  end

  // Priority pick of the lowest matching range. The index is 0 when nothing matches.
  always_comb begin
    match_index = '0;
    for (int r = RANGE_COUNT - 1; r >= 0; r--) begin
      if (match_vector[r]) begin
        match_index = INDEX_WIDTH'(r);
      end
    end
  end

  // S1: capture the address on a request handshake. Empty the stage when it drains without a refill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      if (addr_ready) begin
        s1_valid <= addr_valid;
      end
      if (addr_fire) begin
        s1_addr <= addr;
      end
    end
  end

  // S2: register the decode result of S1. Hold it while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_hit    <= 1'b0;
      s2_vector <= '0;
      s2_index  <= '0;
    end else begin
      if (s2_free) begin
        s2_valid <= s1_valid;
      end
      if (s2_load) begin
        s2_hit    <= |match_vector;
        s2_vector <= match_vector;
        s2_index  <= match_index;
      end
    end
  end

endmodule
